// File: rtl/mul_serial_acc.sv
// Bit-serial shift-and-add multiplier with optional accumulation.
// One multiplier bit is consumed per cycle, LSB first; two's-complement mode weights the MSB negatively.
module mul_serial_acc #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+4,
   parameter bit SIGNED    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_acc,
   input  logic [WIDTH-1:0]     i_data0,
   input  logic [WIDTH-1:0]     i_data1,
   output logic [ACC_WIDTH-1:0] o_data,
   output logic                 o_valid
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_r,  state_nxt_s;
   logic [CNT_W-1:0]       cnt_r,    cnt_nxt_s;
   logic [WIDTH-1:0]       mplier_r, mplier_nxt_s;
   logic [WIDTH-1:0]       mcand_r,  mcand_nxt_s;
   logic [ACC_WIDTH-1:0]   psum_r,   psum_nxt_s;
   logic [ACC_WIDTH-1:0]   data_r,   data_nxt_s;
   logic                   valid_r,  valid_nxt_s;
   logic                   ready_r,  ready_nxt_s;

   logic                   accept_s;
   logic                   last_s;
   logic [ACC_WIDTH-1:0]   term_s;
   logic [ACC_WIDTH-1:0]   step_s;

   function automatic logic [ACC_WIDTH-1:0] extend(input logic [WIDTH-1:0] v);
      logic [ACC_WIDTH-1:0] r;
      if (SIGNED) begin
         r = {{(ACC_WIDTH-WIDTH){v[WIDTH-1]}}, v};
      end else begin
         r = {{(ACC_WIDTH-WIDTH){1'b0}}, v};
      end
      return r;
   endfunction

   assign o_ready = ready_r;
   assign o_data  = data_r;
   assign o_valid = valid_r;

   assign accept_s = i_valid && ready_r;
   assign last_s   = (cnt_r == CNT_LAST);
   assign term_s   = extend(mcand_r) << cnt_r;

   // One shift-and-add step; the top multiplier bit carries negative weight in signed mode
   always_comb begin
      step_s = psum_r;
      if (mplier_r[cnt_r]) begin
         if (SIGNED && last_s) begin
            step_s = psum_r - term_s;
         end else begin
            step_s = psum_r + term_s;
         end
      end else begin
         step_s = psum_r;
      end
   end

   // Next-state and datapath selection; clr overrides everything
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      mplier_nxt_s = mplier_r;
      mcand_nxt_s  = mcand_r;
      psum_nxt_s   = psum_r;
      data_nxt_s   = data_r;
      valid_nxt_s  = 1'b0;

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               // Accumulating reads the result currently on o_data
               state_nxt_s  = ST_BUSY;
               cnt_nxt_s    = {CNT_W{1'b0}};
               mplier_nxt_s = i_data0;
               mcand_nxt_s  = i_data1;
               psum_nxt_s   = i_acc ? data_r : {ACC_WIDTH{1'b0}};
            end else begin
               state_nxt_s  = ST_IDLE;
            end
         end
         ST_BUSY: begin
            psum_nxt_s = step_s;
            if (last_s) begin
               state_nxt_s = ST_DONE;
               cnt_nxt_s   = {CNT_W{1'b0}};
               data_nxt_s  = step_s;
               valid_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
            psum_nxt_s  = {ACC_WIDTH{1'b0}};
         end
      endcase

      if (clr) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = {CNT_W{1'b0}};
         psum_nxt_s  = {ACC_WIDTH{1'b0}};
         data_nxt_s  = {ACC_WIDTH{1'b0}};
         valid_nxt_s = 1'b0;
      end else begin
         valid_nxt_s = valid_nxt_s;
      end

      ready_nxt_s = (state_nxt_s != ST_BUSY);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         mcand_r  <= {WIDTH{1'b0}};
         psum_r   <= {ACC_WIDTH{1'b0}};
         data_r   <= {ACC_WIDTH{1'b0}};
         valid_r  <= 1'b0;
         ready_r  <= 1'b1;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         mplier_r <= mplier_nxt_s;
         mcand_r  <= mcand_nxt_s;
         psum_r   <= psum_nxt_s;
         data_r   <= data_nxt_s;
         valid_r  <= valid_nxt_s;
         ready_r  <= ready_nxt_s;
      end
   end

endmodule

// File: tb/tb_mul_serial_acc.sv
// Bench for mul_serial_acc: three parameterisations share one stimulus stream,
// each checked against an integer-arithmetic model of multiply-accumulate modulo 2^ACC_WIDTH.
module tb_mul_serial_acc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_acc = 1'b0;
   logic [7:0]  d0 = 8'd0;
   logic [7:0]  d1 = 8'd0;

   logic        ready_a, ready_b, ready_c;
   logic        valid_a, valid_b, valid_c;
   logic [19:0] data_a, data_b;
   logic [15:0] data_c;

   int n_checks = 0;
   int n_fail   = 0;

   longint cur_a = 0, cur_b = 0, cur_c = 0;
   longint pend_a = 0, pend_b = 0, pend_c = 0;

   always #5 clk = ~clk;

   mul_serial_acc #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .i_valid(i_valid), .o_ready(ready_a),
      .i_acc(i_acc), .i_data0(d0), .i_data1(d1), .o_data(data_a), .o_valid(valid_a));

   mul_serial_acc #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .i_valid(i_valid), .o_ready(ready_b),
      .i_acc(i_acc), .i_data0(d0), .i_data1(d1), .o_data(data_b), .o_valid(valid_b));

   mul_serial_acc #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .clr(clr), .i_valid(i_valid), .o_ready(ready_c),
      .i_acc(i_acc), .i_data0(d0), .i_data1(d1), .o_data(data_c), .o_valid(valid_c));

   function automatic longint model(input int accw, input bit sgn, input logic [7:0] a,
                                    input logic [7:0] b, input bit acc, input longint prev);
      longint av, bv, s;
      av = sgn ? longint'($signed(a)) : longint'(a);
      bv = sgn ? longint'($signed(b)) : longint'(b);
      s  = (acc ? prev : 64'sd0) + av * bv;
      return s & ((longint'(1) << accw) - 1);
   endfunction

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_data_a"}, longint'(data_a), cur_a);
      chk({tag, "_data_b"}, longint'(data_b), cur_b);
      chk({tag, "_data_c"}, longint'(data_c), cur_c);
      chk({tag, "_valid"}, longint'({valid_a, valid_b, valid_c}), 0);
      chk({tag, "_ready"}, longint'({ready_a, ready_b, ready_c}), 7);
   endtask

   // Present operands at a negedge where the block is ready
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input bit acc);
      chk("ready_at_accept", longint'({ready_a, ready_b, ready_c}), 7);
      i_valid = 1'b1;
      d0      = a;
      d1      = b;
      i_acc   = acc;
      pend_a  = model(20, 1'b1, a, b, acc, cur_a);
      pend_b  = model(20, 1'b0, a, b, acc, cur_b);
      pend_c  = model(16, 1'b1, a, b, acc, cur_c);
   endtask

   // Run through the accept edge and the busy phase; returns at the negedge of the result cycle
   task automatic finish_op();
      int  n = 0;
      int  low = 0;
      bit  seen = 1'b0;
      @(posedge clk);
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            i_valid = 1'b0;
            d0      = 8'($urandom);
            d1      = 8'($urandom);
            i_acc   = 1'($urandom);
         end
         if (valid_a) begin
            seen = 1'b1;
         end else begin
            if (!ready_a) low++;
            if (n == 4) chk("hold_during_busy", longint'(data_a), cur_a);
         end
      end
      chk("latency", n, 9);
      chk("busy_cycles", low, 8);
      chk("valid_all", longint'({valid_b, valid_c}), 3);
      chk("ready_in_done", longint'({ready_a, ready_b, ready_c}), 7);
      chk("result_a", longint'(data_a), pend_a);
      chk("result_b", longint'(data_b), pend_b);
      chk("result_c", longint'(data_c), pend_c);
      cur_a = pend_a;
      cur_b = pend_b;
      cur_c = pend_c;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      check_outputs("after_pulse");
   endtask

   task automatic watch_no_valid(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (valid_a || valid_b || valid_c) seen++;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      // Reset state, including while reset is held
      repeat (2) @(negedge clk);
      check_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs("after_reset");

      // Directed signed / unsigned products
      start_op(8'd3, 8'd5, 1'b0);      finish_op(); chk("3x5", longint'(data_a), 15); idle_cycle();
      start_op(8'hFD, 8'd7, 1'b0);     finish_op(); chk("m3x7", longint'($signed(data_a)), -21); idle_cycle();
      start_op(8'h80, 8'h80, 1'b0);    finish_op(); chk("m128xm128", longint'(data_a), 16384); idle_cycle();
      start_op(8'h7F, 8'h80, 1'b0);    finish_op(); chk("127xm128", longint'($signed(data_a)), -16256); idle_cycle();
      start_op(8'hFF, 8'hFF, 1'b0);    finish_op(); chk("u255x255", longint'(data_b), 65025); idle_cycle();
      start_op(8'd0, 8'd200, 1'b0);    finish_op(); chk("u0x200", longint'(data_b), 0); idle_cycle();

      // Back-to-back accumulation, each accept landing in the result cycle
      start_op(8'd2, 8'd3, 1'b0);      finish_op(); chk("b2b_1", longint'(data_a), 6);
      start_op(8'd4, 8'd5, 1'b1);      finish_op(); chk("b2b_2", longint'(data_a), 26);
      start_op(8'd1, 8'hFA, 1'b1);     finish_op(); chk("b2b_3", longint'(data_a), 20);
      idle_cycle();

      // Synchronous clear while cnt is 4
      start_op(8'd100, 8'd100, 1'b0);
      @(posedge clk);
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         if (n == 1) i_valid = 1'b0;
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      cur_a = 0; cur_b = 0; cur_c = 0;
      check_outputs("after_clr");
      watch_no_valid("no_valid_after_clr", 12);
      start_op(8'd2, 8'd2, 1'b1);      finish_op(); chk("2x2_after_clr", longint'(data_a), 4); idle_cycle();

      // Asynchronous reset in the middle of an operation
      start_op(8'd50, 8'd9, 1'b1);
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      cur_a = 0; cur_b = 0; cur_c = 0;
      check_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs("reset_release");
      watch_no_valid("no_valid_after_reset", 12);

      // Repeated accumulation exercising wrap in the 16-bit accumulator
      start_op(8'd127, 8'd127, 1'b0);  finish_op();
      for (int k = 0; k < 4; k++) begin
         if (k == 2) idle_cycle();
         start_op(8'd127, 8'd127, 1'b1); finish_op();
      end
      chk("acc5_wrap16", longint'(data_c), 15109);
      chk("acc5_full20", longint'(data_a), 80645);
      idle_cycle();

      // Random operands, randomly back-to-back or separated by idle cycles
      for (int k = 0; k < 25; k++) begin
         start_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         finish_op();
         if ($urandom_range(0, 1) == 0) idle_cycle();
      end
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_serial_acc.md
MUL_SERIAL_ACC -- requirements
Module: mul_serial_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (>=2).
REQ-002 SHALL have parameter ACC_WIDTH, default 2*WIDTH+4, accumulator/result width (>=2*WIDTH).
REQ-003 SHALL have parameter SIGNED, default 1: 1 means two's-complement operands, 0 means unsigned operands.
REQ-004 SHALL have port clk  in  1  sole clock, all state on the rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port clr  in  1  synchronous clear: abort the operation and zero the accumulator.
REQ-007 SHALL have port i_valid  in  1  operands present.
REQ-008 SHALL have port o_ready  out  1  block can accept operands this cycle.
REQ-009 SHALL have port i_acc  in  1  sampled at accept: 1 adds the product to the current accumulator, 0 starts from zero.
REQ-010 SHALL have port i_data0  in  WIDTH  multiplier, consumed one bit per cycle, LSB first.
REQ-011 SHALL have port i_data1  in  WIDTH  multiplicand.
REQ-012 SHALL have port o_data  out  ACC_WIDTH  signed accumulated result.
REQ-013 SHALL have port o_valid  out  1  one-cycle pulse when o_data is updated.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 SHALL define accept as i_valid && o_ready; o_ready SHALL be 1 in IDLE and DONE and 0 in BUSY.
REQ-016 On accept SHALL register i_data0, i_data1 and i_acc, load the partial sum with (i_acc ? o_data : 0), clear bit counter cnt to 0, and enter BUSY.
REQ-017 In BUSY, each cycle SHALL add (multiplicand extended to ACC_WIDTH) << cnt to the partial sum when bit cnt of the multiplier is 1, then increment cnt.
REQ-018 Multiplicand extension SHALL be sign extension when SIGNED=1 and zero extension when SIGNED=0.
REQ-019 When SIGNED=1 and cnt==WIDTH-1, the shifted term SHALL be subtracted instead of added (negative MSB weight).
REQ-020 After the cycle with cnt==WIDTH-1, SHALL enter DONE, copy the partial sum to o_data, and assert o_valid for exactly that cycle.
REQ-021 Latency SHALL be WIDTH+1 cycles from the accept edge to o_valid=1.
REQ-022 From DONE, SHALL enter BUSY on accept (back-to-back operation, one op per WIDTH+1 cycles), otherwise IDLE.
REQ-023 All arithmetic SHALL wrap modulo 2^ACC_WIDTH with no saturation and no overflow flag.
REQ-024 o_data SHALL hold its value between o_valid pulses.
REQ-025 i_data0/i_data1 changes during BUSY SHALL have no effect.
REQ-026 clr=1 SHALL take priority over accept and FSM progress: next state IDLE, cnt=0, partial sum=0, o_data=0, o_valid=0.
REQ-027 Accept with i_acc=1 in DONE SHALL use the o_data value being presented in that same cycle.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, partial sum=0, o_data=0 and o_valid=0; o_ready SHALL be 1 immediately after reset release.
REQ-029 Reset during BUSY SHALL discard the operation, and no o_valid SHALL follow.

Verification
REQ-030 WIDTH=8, SIGNED=1: accept 3*5, i_acc=0 -> o_valid exactly 9 cycles later, o_data=15, o_ready=0 for 8 cycles.
REQ-031 SIGNED=1: -3*7 -> o_data=-21; -128*-128 -> o_data=16384; 127*-128 -> o_data=-16256.
REQ-032 SIGNED=0: 255*255 -> o_data=65025; 0*200 -> o_data=0 with o_valid still pulsed.
REQ-033 Back-to-back: accept 2*3 (i_acc=0), then in DONE accept 4*5 (i_acc=1), then 1*-6 (i_acc=1) -> o_data 6, 26, 20 at cycles 9, 18, 27.
REQ-034 clr asserted at cnt=4 of 100*100 -> next cycle IDLE, o_data=0, no o_valid; new accept of 2*2 -> 4.
REQ-035 rst_n pulsed low mid-BUSY -> all outputs 0 and o_ready=1 after release, no stray o_valid; ACC_WIDTH=16 with 127*127 accumulated 5 times -> 80645 mod 65536 = 15109.
